ram_port_arbiter: RTL

RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

---
 rtl/ram_port_arbiter.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/ram_port_arbiter.sv
// Two-requester arbiter in front of a single-port RAM with registered read data.
// Alternating priority, bounded lock bursts, and a one-cycle registered read response tag.
module ram_port_arbiter #(
    parameter int unsigned MAX_LOCK = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_a,
    input  logic        req_b,
    input  logic        lock_a,
    input  logic        lock_b,
    input  logic        write_a,
    input  logic        write_b,
    input  logic [7:0]  addr_a,
    input  logic [7:0]  addr_b,
    input  logic [63:0] wdata_a,
    input  logic [63:0] wdata_b,
    output logic        gnt_a,
    output logic        gnt_b,
    output logic        rvalid_a,
    output logic        rvalid_b,
    output logic [63:0] rdata,
    output logic [7:0]  ram_address,
    output logic [63:0] ram_in,
    output logic        ram_write,
    input  logic [63:0] ram_out
);

    localparam logic [3:0] MAX_BEATS = 4'(MAX_LOCK);

    logic        ptr_q, ptr_d;            // 1'b0 favours A
    logic        lock_vld_q, lock_vld_d;
    logic        lock_own_q, lock_own_d;  // 1'b0 = A owns the lock
    logic [3:0]  beat_q, beat_d;
    logic [1:0]  rsp_q, rsp_d;            // {valid, owner}
    logic [7:0]  addr_q, addr_d;
    logic [63:0] wdata_q, wdata_d;

    logic        lock_hold_s;
    logic        gnt_a_s, gnt_b_s, any_gnt_s;
    logic        sel_write_s, sel_lock_s;
    logic [7:0]  sel_addr_s;
    logic [63:0] sel_wdata_s;
    logic [3:0]  beat_inc_s;

    // Grant decision: live lock first, then pointer on contention, else the lone requester.
    always_comb begin
        lock_hold_s = 1'b0;
        gnt_a_s     = 1'b0;
        gnt_b_s     = 1'b0;
        if (lock_vld_q && (beat_q < MAX_BEATS)) begin
            if (lock_own_q) begin
                lock_hold_s = req_b & lock_b;
            end else begin
                lock_hold_s = req_a & lock_a;
            end
        end else begin
            lock_hold_s = 1'b0;
        end
        if (reset) begin
            gnt_a_s = 1'b0;
            gnt_b_s = 1'b0;
        end else if (lock_hold_s) begin
            gnt_a_s = ~lock_own_q;
            gnt_b_s = lock_own_q;
        end else if (req_a && req_b) begin
            gnt_a_s = ~ptr_q;
            gnt_b_s = ptr_q;
        end else begin
            gnt_a_s = req_a;
            gnt_b_s = req_b;
        end
    end

    // Steer the granted requester's command onto the RAM port.
    always_comb begin
        any_gnt_s   = gnt_a_s | gnt_b_s;
        sel_write_s = gnt_b_s ? write_b : write_a;
        sel_lock_s  = gnt_b_s ? lock_b  : lock_a;
        sel_addr_s  = gnt_b_s ? addr_b  : addr_a;
        sel_wdata_s = gnt_b_s ? wdata_b : wdata_a;
        if (any_gnt_s) begin
            ram_address = sel_addr_s;
            ram_in      = sel_wdata_s;
            ram_write   = sel_write_s;
        end else begin
            ram_address = addr_q;
            ram_in      = wdata_q;
            ram_write   = 1'b0;
        end
    end

    // Next-state: pointer, lock burst bookkeeping, shadows and read response tag.
    always_comb begin
        ptr_d      = ptr_q;
        lock_vld_d = 1'b0;
        lock_own_d = lock_own_q;
        beat_d     = 4'd0;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        beat_inc_s = lock_hold_s ? (beat_q + 4'd1) : 4'd1;
        rsp_d      = {any_gnt_s & ~sel_write_s, gnt_b_s};
        if (any_gnt_s) begin
            ptr_d   = gnt_a_s;
            addr_d  = sel_addr_s;
            wdata_d = sel_wdata_s;
            // A burst that hits its cap ends right here so the other side is served next.
            if (sel_lock_s && (beat_inc_s < MAX_BEATS)) begin
                lock_vld_d = 1'b1;
                lock_own_d = gnt_b_s;
                beat_d     = beat_inc_s;
            end else begin
                lock_vld_d = 1'b0;
                beat_d     = 4'd0;
            end
        end else begin
            lock_vld_d = 1'b0;
            beat_d     = 4'd0;
        end
    end

    // State registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ptr_q      <= 1'b0;
            lock_vld_q <= 1'b0;
            lock_own_q <= 1'b0;
            beat_q     <= 4'd0;
            rsp_q      <= 2'b00;
            addr_q     <= 8'd0;
            wdata_q    <= 64'd0;
        end else begin
            ptr_q      <= ptr_d;
            lock_vld_q <= lock_vld_d;
            lock_own_q <= lock_own_d;
            beat_q     <= beat_d;
            rsp_q      <= rsp_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
        end
    end

    assign gnt_a    = gnt_a_s;
    assign gnt_b    = gnt_b_s;
    assign rvalid_a = rsp_q[1] & ~rsp_q[0];
    assign rvalid_b = rsp_q[1] & rsp_q[0];
    assign rdata    = ram_out;

endmodule
